// File: rtl/clip_seq.sv
// Memory-to-memory signed clamp sequencer: reads len words, clamps each to
// [min_val,max_val], writes them back out and counts saturated elements.
module clip_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] min_val,
    input  logic [DATA_W-1:0] max_val,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_gnt,
    output logic [CNT_W-1:0]  sat_hi_cnt,
    output logic [CNT_W-1:0]  sat_lo_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_wr_data;
    logic [CNT_W-1:0]  r_sat_hi;
    logic [CNT_W-1:0]  r_sat_lo;
    logic              r_cfg_err;

    logic              w_hi;
    logic              w_lo;
    logic [DATA_W-1:0] w_clamped;
    logic [CNT_W:0]    w_idx_inc;
    logic              w_last;
    logic              w_bad_cfg;

    assign w_hi      = $signed(rd_data) > $signed(r_max);
    assign w_lo      = $signed(rd_data) < $signed(r_min);
    assign w_clamped = w_hi ? r_max : (w_lo ? r_min : rd_data);
    // One extra bit so idx+1 cannot wrap when len is at its maximum.
    assign w_idx_inc = {1'b0, r_idx} + {{CNT_W{1'b0}}, 1'b1};
    assign w_last    = w_idx_inc >= {1'b0, r_len};
    assign w_bad_cfg = $signed(min_val) > $signed(max_val);

    // NOTE: every path assigns w_next through the default first, so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad_cfg)          w_next = S_ERR;
                    else if (len == '0)     w_next = S_FIN;
                    else                    w_next = S_RD;
                end
            end
            S_RD:    if (rd_gnt) w_next = S_CAP;
            S_CAP:   w_next = S_WR;
            S_WR:    if (wr_gnt) w_next = w_last ? S_FIN : S_RD;
            S_ERR:   w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: the datapath registers are reset too, since every output must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src     <= '0;
            r_dst     <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_wr_data <= '0;
            r_sat_hi  <= '0;
            r_sat_lo  <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src     <= src_base;
                        r_dst     <= dst_base;
                        r_len     <= len;
                        r_min     <= min_val;
                        r_max     <= max_val;
                        r_idx     <= '0;
                        r_sat_hi  <= '0;
                        r_sat_lo  <= '0;
                        r_cfg_err <= 1'b0;
                    end
                end
                S_CAP: begin
                    r_wr_data <= w_clamped;
                    if (w_hi && (r_sat_hi != '1)) r_sat_hi <= r_sat_hi + CNT_W'(1);
                    if (w_lo && (r_sat_lo != '1)) r_sat_lo <= r_sat_lo + CNT_W'(1);
                end
                S_WR:    if (wr_gnt) r_idx <= w_idx_inc[CNT_W-1:0];
                S_ERR:   r_cfg_err <= 1'b1;
                default: ;
            endcase
        end
    end

    // Requests decode straight from state, so an async reset drops them immediately.
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);
    assign rd_req     = (r_state == S_RD);
    assign wr_req     = (r_state == S_WR);
    assign rd_addr    = r_src + ADDR_W'(r_idx);
    assign wr_addr    = r_dst + ADDR_W'(r_idx);
    assign wr_data    = r_wr_data;
    assign cfg_err    = r_cfg_err;
    assign sat_hi_cnt = r_sat_hi;
    assign sat_lo_cnt = r_sat_lo;

endmodule

// File: tb/tb_clip_seq.sv
// Self-checking bench for clip_seq: a memory/arbiter responder with read and
// write scoreboards, plus one task per scenario.
module tb_clip_seq;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic [CNT_W-1:0]  len = '0;
    logic [DATA_W-1:0] min_val = '0;
    logic [DATA_W-1:0] max_val = '0;
    logic              busy, done, cfg_err;
    logic              rd_req, wr_req;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_gnt = 1'b0;
    logic              wr_gnt = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic [CNT_W-1:0]  sat_hi_cnt, sat_lo_cnt;

    always #5 clk = ~clk;

    clip_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_base(src_base), .dst_base(dst_base), .len(len),
        .min_val(min_val), .max_val(max_val),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .sat_hi_cnt(sat_hi_cnt), .sat_lo_cnt(sat_lo_cnt)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] mem [0:65535];
    logic [ADDR_W-1:0] exp_rd_q [$];
    wr_exp_t           exp_wr_q [$];
    bit                gnt_random = 1'b0;
    bit                wr_hold = 1'b0;
    int                req_cycles = 0;

    // Responder state: outstanding requests and read data due next cycle.
    bit                rd_pend = 1'b0;
    bit                wr_pend = 1'b0;
    logic [ADDR_W-1:0] rd_pend_addr;
    logic [ADDR_W-1:0] wr_pend_addr;
    logic [DATA_W-1:0] wr_pend_data;
    bit                data_due = 1'b0;
    logic [ADDR_W-1:0] data_addr;
    logic [ADDR_W-1:0] pop_addr;
    wr_exp_t           pop_wr;

    // Arbiter/SRAM model, driven mid-cycle so the DUT samples stable inputs.
    always @(negedge clk) begin
        if (rst) begin
            rd_pend  = 1'b0;
            wr_pend  = 1'b0;
            data_due = 1'b0;
            rd_gnt   = 1'b0;
            wr_gnt   = 1'b0;
        end else begin
            rd_data  = data_due ? mem[data_addr] : $urandom;
            data_due = 1'b0;
            checks++;
            if (rd_req && wr_req) begin
                errors++;
                $display("FAIL req_overlap: rd_req=%b wr_req=%b, required not both high", rd_req, wr_req);
            end
            if (rd_req || wr_req) req_cycles++;
            if (rd_pend) begin
                checks++;
                if (rd_req !== 1'b1 || rd_addr !== rd_pend_addr) begin
                    errors++;
                    $display("FAIL rd_hold: rd_req=%b addr=%h, required 1 addr=%h", rd_req, rd_addr, rd_pend_addr);
                end
            end
            if (wr_pend) begin
                checks++;
                if (wr_req !== 1'b1 || wr_addr !== wr_pend_addr || wr_data !== wr_pend_data) begin
                    errors++;
                    $display("FAIL wr_hold: wr_req=%b addr=%h data=%h, required 1 addr=%h data=%h",
                             wr_req, wr_addr, wr_data, wr_pend_addr, wr_pend_data);
                end
            end
            // Grants may be high with no request pending; the DUT must ignore them.
            rd_gnt = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_gnt = wr_hold ? 1'b0 : (gnt_random ? 1'($urandom_range(0, 1)) : 1'b1);
            if (rd_req && rd_gnt) begin
                checks++;
                if (exp_rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: addr=%h, required no read", rd_addr);
                end else begin
                    pop_addr = exp_rd_q.pop_front();
                    if (rd_addr !== pop_addr) begin
                        errors++;
                        $display("FAIL rd_addr: got %h, required %h", rd_addr, pop_addr);
                    end
                end
                data_due  = 1'b1;
                data_addr = rd_addr;
            end
            rd_pend      = rd_req && !rd_gnt;
            rd_pend_addr = rd_addr;
            if (wr_req && wr_gnt) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: addr=%h data=%h, required no write", wr_addr, wr_data);
                end else begin
                    pop_wr = exp_wr_q.pop_front();
                    if (wr_addr !== pop_wr.addr || wr_data !== pop_wr.data) begin
                        errors++;
                        $display("FAIL wr_beat: got addr=%h data=%0d, required addr=%h data=%0d",
                                 wr_addr, $signed(wr_data), pop_wr.addr, $signed(pop_wr.data));
                    end
                end
                mem[wr_addr] = wr_data;
            end
            wr_pend      = wr_req && !wr_gnt;
            wr_pend_addr = wr_addr;
            wr_pend_data = wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] clamp_ref(input logic signed [DATA_W-1:0] v,
                                                    input logic signed [DATA_W-1:0] lo,
                                                    input logic signed [DATA_W-1:0] hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Launches one operation and waits for done. cycles counts inclusively from
    // the start cycle to the done cycle, or is -1 if done never arrives.
    task automatic run_op(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                          input logic [CNT_W-1:0] n, input logic [DATA_W-1:0] lo,
                          input logic [DATA_W-1:0] hi, input int restart_at,
                          output int cycles, output logic err_at_done, output logic done_after);
        @(negedge clk);
        src_base = src; dst_base = dst; len = n; min_val = lo; max_val = hi;
        start = 1'b1;
        cycles = 1;
        err_at_done = 1'bx;
        done_after = 1'bx;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            cycles++;
            start = (cycles == restart_at);
            if (start) begin
                src_base = 16'h1234; dst_base = 16'h4321; len = 16'd9;
                min_val = 32'd0; max_val = 32'd1;
            end
            if (done) begin
                err_at_done = cfg_err;
                @(negedge clk);
                start = 1'b0;
                done_after = done;
                return;
            end
        end
        start = 1'b0;
        cycles = -1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cfg_err, rd_req, wr_req} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: busy/done/cfg_err/rd_req/wr_req=%b, required 00000",
                     {busy, done, cfg_err, rd_req, wr_req});
        end
        checks++;
        if ({rd_addr, wr_addr, wr_data, sat_hi_cnt, sat_lo_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data: rd_addr=%h wr_addr=%h wr_data=%h hi=%0d lo=%0d, required all 0",
                     rd_addr, wr_addr, wr_data, sat_hi_cnt, sat_lo_cnt);
        end
        #2 rst = 1'b0;
    endtask

    // Loads {5,-20,30,10} at src and queues the {5,-10,10,10} result for dst.
    task automatic load_basic(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst);
        mem[src]     = 32'd5;
        mem[src + 1] = -32'sd20;
        mem[src + 2] = 32'd30;
        mem[src + 3] = 32'd10;
        for (int i = 0; i < 4; i++) exp_rd_q.push_back(src + ADDR_W'(i));
        exp_wr_q.push_back('{dst,     32'd5});
        exp_wr_q.push_back('{dst + 1, -32'sd10});
        exp_wr_q.push_back('{dst + 2, 32'd10});
        exp_wr_q.push_back('{dst + 3, 32'd10});
    endtask

    task automatic test_basic(input string tag, input logic [ADDR_W-1:0] dst, input bit check_time);
        int   cyc;
        logic e, da;
        load_basic(16'h0010, dst);
        run_op(16'h0010, dst, 16'd4, -32'sd10, 32'sd10, 0, cyc, e, da);
        checks++;
        if ((check_time && cyc != 14) || cyc < 0) begin
            errors++;
            $display("FAIL %s_latency: %0d cycles, required 14", tag, cyc);
        end
        checks++;
        if (sat_hi_cnt !== 16'd1 || sat_lo_cnt !== 16'd1) begin
            errors++;
            $display("FAIL %s_sat: hi=%0d lo=%0d, required hi=1 lo=1", tag, sat_hi_cnt, sat_lo_cnt);
        end
        checks++;
        if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d reads and %0d writes left, required 0 and 0",
                     tag, exp_rd_q.size(), exp_wr_q.size());
        end
        checks++;
        if (e !== 1'b0 || da !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_end: cfg_err=%b done_next=%b busy=%b, required 0 0 0", tag, e, da, busy);
        end
    endtask

    task automatic test_random_gnt;
        int          cyc;
        logic        e, da;
        int          hi_n, lo_n;
        logic signed [DATA_W-1:0] v;
        gnt_random = 1'b1;
        test_basic("randgnt", 16'h0300, 1'b0);
        hi_n = 0;
        lo_n = 0;
        for (int i = 0; i < 6; i++) begin
            v = DATA_W'($urandom_range(0, 4000)) - 32'sd2000;
            mem[16'h0800 + i] = v;
            exp_rd_q.push_back(16'h0800 + ADDR_W'(i));
            exp_wr_q.push_back('{16'h0900 + ADDR_W'(i), clamp_ref(v, -32'sd700, 32'sd900)});
            if (v > 32'sd900) hi_n++;
            if (v < -32'sd700) lo_n++;
        end
        run_op(16'h0800, 16'h0900, 16'd6, -32'sd700, 32'sd900, 0, cyc, e, da);
        checks++;
        if (cyc < 20 || sat_hi_cnt !== CNT_W'(hi_n) || sat_lo_cnt !== CNT_W'(lo_n)) begin
            errors++;
            $display("FAIL randvec: cycles=%0d hi=%0d lo=%0d, required cycles>=20 hi=%0d lo=%0d",
                     cyc, sat_hi_cnt, sat_lo_cnt, hi_n, lo_n);
        end
        checks++;
        if (exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL randvec_drain: %0d writes left, required 0", exp_wr_q.size());
        end
        gnt_random = 1'b0;
    endtask

    task automatic test_zero_len;
        int   cyc;
        logic e, da;
        req_cycles = 0;
        run_op(16'h0010, 16'h0600, 16'd0, -32'sd10, 32'sd10, 0, cyc, e, da);
        checks++;
        if (cyc != 2 || req_cycles != 0) begin
            errors++;
            $display("FAIL zero_len: cycles=%0d req_cycles=%0d, required 2 and 0", cyc, req_cycles);
        end
        checks++;
        if (sat_hi_cnt !== '0 || sat_lo_cnt !== '0 || da !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_cnt: hi=%0d lo=%0d done_next=%b, required 0 0 0", sat_hi_cnt, sat_lo_cnt, da);
        end
    endtask

    task automatic test_cfg_err;
        int   cyc;
        logic e, da;
        req_cycles = 0;
        run_op(16'h0010, 16'h0600, 16'd3, 32'sd5, -32'sd5, 0, cyc, e, da);
        checks++;
        if (e !== 1'b1 || cyc != 3 || req_cycles != 0) begin
            errors++;
            $display("FAIL cfg_err: cfg_err=%b cycles=%0d req_cycles=%0d, required 1 3 0", e, cyc, req_cycles);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_hold: cfg_err=%b, required 1", cfg_err);
        end
        mem[16'h0700] = 32'd7;
        exp_rd_q.push_back(16'h0700);
        exp_wr_q.push_back('{16'h0710, 32'd5});
        run_op(16'h0700, 16'h0710, 16'd1, -32'sd5, 32'sd5, 0, cyc, e, da);
        checks++;
        if (e !== 1'b0 || cyc != 5 || sat_hi_cnt !== 16'd1 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL cfg_err_clear: cfg_err=%b cycles=%0d hi=%0d writes_left=%0d, required 0 5 1 0",
                     e, cyc, sat_hi_cnt, exp_wr_q.size());
        end
    endtask

    task automatic test_wrap_restart;
        int   cyc;
        logic e, da;
        int   busy_seen;
        mem[16'hFFFE] = 32'd200;
        mem[16'hFFFF] = -32'sd50;
        mem[16'h0000] = -32'sd300;
        exp_rd_q.push_back(16'hFFFE);
        exp_rd_q.push_back(16'hFFFF);
        exp_rd_q.push_back(16'h0000);
        exp_wr_q.push_back('{16'h0400, 32'd100});
        exp_wr_q.push_back('{16'h0401, -32'sd50});
        exp_wr_q.push_back('{16'h0402, -32'sd100});
        run_op(16'hFFFE, 16'h0400, 16'd3, -32'sd100, 32'sd100, 5, cyc, e, da);
        checks++;
        if (cyc != 11 || sat_hi_cnt !== 16'd1 || sat_lo_cnt !== 16'd1) begin
            errors++;
            $display("FAIL wrap: cycles=%0d hi=%0d lo=%0d, required 11 1 1", cyc, sat_hi_cnt, sat_lo_cnt);
        end
        busy_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        checks++;
        if (busy_seen != 0 || exp_rd_q.size() != 0 || exp_wr_q.size() != 0) begin
            errors++;
            $display("FAIL restart_ignored: busy_cycles=%0d reads_left=%0d writes_left=%0d, required 0 0 0",
                     busy_seen, exp_rd_q.size(), exp_wr_q.size());
        end
    endtask

    task automatic test_reset_mid_wr;
        bit seen;
        mem[16'h0020] = 32'd5;
        exp_rd_q.push_back(16'h0020);
        wr_hold = 1'b1;
        @(negedge clk);
        src_base = 16'h0020; dst_base = 16'h0030; len = 16'd2;
        min_val = -32'sd10; max_val = 32'sd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = wr_req;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_setup: wr_req never rose, required 1 within 20 cycles");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wr_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_wr_req: wr_req=%b after async reset, required 0", wr_req);
        end
        checks++;
        if ({busy, done, cfg_err, rd_req, rd_addr, wr_addr, wr_data, sat_hi_cnt, sat_lo_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_outputs: busy=%b done=%b rd_req=%b wr_addr=%h wr_data=%h, required all 0",
                     busy, done, rd_req, wr_addr, wr_data);
        end
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        wr_hold = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
        test_basic("post_rst", 16'h0500, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic("basic", 16'h0200, 1'b1);
        test_random_gnt();
        test_zero_len();
        test_cfg_err();
        test_wrap_restart();
        test_reset_mid_wr();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
